// File: rtl/w1_encode_absorb_pkg.sv
// ============================================================================
// dilithium_pkg : ML-DSA-87 constants and the absorb-sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package dilithium_pkg;

  localparam int DSA_K       = 8;
  localparam int DSA_N       = 256;
  localparam int DSA_Q       = 8380417;
  localparam int DSA_W1_BITS = 4;
  localparam int DSA_MU_BITS = 512;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MU_RD  = 3'd1,
    S_MU_CAP = 3'd2,
    S_W1_RD  = 3'd3,
    S_SEND   = 3'd4,
    S_FIN    = 3'd5
  } absorb_state_t;

endpackage

`default_nettype wire

// File: rtl/w1_encode_absorb_if.sv
// ============================================================================
// w1_encode_absorb_if : SHAKE256 absorb port (data, valid/ready, last, last_len)
// Rev 1.0
// ============================================================================
`default_nettype none

interface w1_encode_absorb_if #(
  parameter int WORD_WIDTH = 64
);
  localparam int LEN_W = $clog2(WORD_WIDTH) + 1;

  logic [WORD_WIDTH-1:0] shake_data_in;
  logic                  in_valid;
  logic                  in_last;
  logic [LEN_W-1:0]      last_len;
  logic                  in_ready;

  modport master (output shake_data_in, in_valid, in_last, last_len, input in_ready);
  modport slave  (input shake_data_in, in_valid, in_last, last_len, output in_ready);
endinterface

`default_nettype wire

// File: rtl/w1_encode_absorb_pack.sv
// ============================================================================
// w1_pack_word : shifts in the low W1_BITS of each coeff of consecutive NTT
//                words, first word ending up in the least significant slice
// Rev 1.0
// ============================================================================
`default_nettype none

module w1_pack_word #(
  parameter int COEFF_WIDTH    = 24,
  parameter int COEFF_PER_WORD = 4,
  parameter int W1_BITS        = 4,
  parameter int WORD_WIDTH     = 64
) (
  input  wire logic                                  clk,
  input  wire logic                                  rst,
  input  wire logic                                  i_load,
  input  wire logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] i_ntt_word,
  output logic      [WORD_WIDTH-1:0]                 o_word,
  output logic                                       o_last_load
);
  localparam int c_slice_w = COEFF_PER_WORD * W1_BITS;
  localparam int c_loads   = WORD_WIDTH / c_slice_w;
  localparam int c_cnt_w   = $clog2(c_loads);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_loads - 1);

  logic [c_slice_w-1:0]      w_slice;
  logic [COEFF_PER_WORD-1:0] w_unused_hi;
  logic [WORD_WIDTH-1:0]     r_sr;
  logic [c_cnt_w-1:0]        r_cnt;

  // Only the low W1_BITS of each coefficient reach the stream.
  for (genvar j = 0; j < COEFF_PER_WORD; j++) begin : g_slice
    assign w_slice[j*W1_BITS +: W1_BITS] = i_ntt_word[j*COEFF_WIDTH +: W1_BITS];
    assign w_unused_hi[j] = |i_ntt_word[j*COEFF_WIDTH+W1_BITS +: COEFF_WIDTH-W1_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sr  <= {w_slice, r_sr[WORD_WIDTH-1:c_slice_w]};
      r_cnt <= (r_cnt == c_cnt_max) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_word      = r_sr;
  assign o_last_load = i_load && (r_cnt == c_cnt_max);
endmodule

`default_nettype wire

// File: rtl/w1_encode_absorb.sv
// ============================================================================
// w1_encode_absorb : streams mu || w1Encode(w1) into the SHAKE256 absorb port.
// Option: W1_RANGE_CHECK_EN adds sticky range_err for coeffs wider than W1_BITS.
// Rev 1.0
// ============================================================================
`default_nettype none

module w1_encode_absorb
  import dilithium_pkg::*;
#(
  parameter int K               = DSA_K,
  parameter int N               = DSA_N,
  parameter int W1_BITS         = DSA_W1_BITS,
  parameter int MU_BITS         = DSA_MU_BITS,
  parameter int WORD_WIDTH      = 64,
  parameter int DATA_ADDR_WIDTH = 12,
  parameter int MU_BASE_OFFSET  = 0,
  parameter int COEFF_WIDTH     = 24,
  parameter int COEFF_PER_WORD  = 4,
  parameter int NTT_ADDR_WIDTH  = 12,
  parameter int W1_BASE_OFFSET  = 0
) (
  input  wire logic                                  clk,
  input  wire logic                                  rst,
  input  wire logic                                  start,
  output logic                                       done,
  output logic                                       busy,
  output logic      [DATA_ADDR_WIDTH-1:0]            addr_mu,
  input  wire logic [WORD_WIDTH-1:0]                 dout_mu,
  output logic      [NTT_ADDR_WIDTH-1:0]             addr_w1,
  input  wire logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] dout_w1,
`ifdef W1_RANGE_CHECK_EN
  output logic                                       range_err,
`endif
  w1_encode_absorb_if.master                         shake
);
  localparam int c_mu_words  = MU_BITS / WORD_WIDTH;
  localparam int c_w1_words  = K * N * W1_BITS / WORD_WIDTH;
  localparam int c_total     = c_mu_words + c_w1_words;
  localparam int c_cnt_w     = $clog2(c_total + 1);
  localparam int c_issues    = WORD_WIDTH / (COEFF_PER_WORD * W1_BITS);
  localparam int c_rd_w      = $clog2(c_issues + 1);
  localparam int c_len_w     = $clog2(WORD_WIDTH) + 1;

  localparam logic [c_cnt_w-1:0]         c_mu_cnt   = c_cnt_w'(c_mu_words);
  localparam logic [c_cnt_w-1:0]         c_mu_last  = c_cnt_w'(c_mu_words - 1);
  localparam logic [c_cnt_w-1:0]         c_last_cnt = c_cnt_w'(c_total - 1);
  localparam logic [c_rd_w-1:0]          c_rd_issue = c_rd_w'(c_issues);
  localparam logic [DATA_ADDR_WIDTH-1:0] c_mu_base  = DATA_ADDR_WIDTH'(MU_BASE_OFFSET);
  localparam logic [NTT_ADDR_WIDTH-1:0]  c_w1_base  = NTT_ADDR_WIDTH'(W1_BASE_OFFSET);

  absorb_state_t          r_state, w_next_state;
  logic [c_cnt_w-1:0]     r_word_cnt;
  logic [c_rd_w-1:0]      r_rd_cnt;
  logic [WORD_WIDTH-1:0]  r_mu_data;
  logic [WORD_WIDTH-1:0]  w_pack_word;
  logic                   w_pack_last;
  logic                   w_capture;
  logic                   w_handshake;
  logic                   w_start_acc;
  logic                   w_is_mu;
  logic                   w_last_word;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_handshake = (r_state == S_SEND) && shake.in_ready;
  assign w_is_mu     = r_word_cnt < c_mu_cnt;
  assign w_last_word = r_word_cnt == c_last_cnt;
  // Read data lags its address by one cycle, so capture starts on the second W1_RD cycle.
  assign w_capture   = (r_state == S_W1_RD) && (r_rd_cnt != '0);

  w1_pack_word #(
    .COEFF_WIDTH    (COEFF_WIDTH),
    .COEFF_PER_WORD (COEFF_PER_WORD),
    .W1_BITS        (W1_BITS),
    .WORD_WIDTH     (WORD_WIDTH)
  ) u_pack (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_capture),
    .i_ntt_word  (dout_w1),
    .o_word      (w_pack_word),
    .o_last_load (w_pack_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    shake.in_valid = 1'b0;
    shake.in_last  = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_MU_RD;
      end
      S_MU_RD:  w_next_state = S_MU_CAP;
      S_MU_CAP: w_next_state = S_SEND;
      S_W1_RD:  if (w_pack_last) w_next_state = S_SEND;
      S_SEND: begin
        shake.in_valid = 1'b1;
        shake.in_last  = w_last_word;
        if (shake.in_ready) begin
          if (w_last_word)                  w_next_state = S_FIN;
          else if (r_word_cnt < c_mu_last)  w_next_state = S_MU_RD;
          else                              w_next_state = S_W1_RD;
        end
      end
      S_FIN: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_rd_cnt   <= '0;
      r_mu_data  <= '0;
      addr_mu    <= c_mu_base;
      addr_w1    <= c_w1_base;
    end else begin
      if (w_start_acc) begin
        r_word_cnt <= '0;
        r_rd_cnt   <= '0;
        addr_mu    <= c_mu_base;
        addr_w1    <= c_w1_base;
      end
      if (r_state == S_MU_CAP) r_mu_data <= dout_mu;
      if (r_state == S_W1_RD) begin
        if (r_rd_cnt < c_rd_issue) addr_w1 <= addr_w1 + 1'b1;
        r_rd_cnt <= w_pack_last ? '0 : r_rd_cnt + 1'b1;
      end
      if (w_handshake) begin
        r_word_cnt <= r_word_cnt + 1'b1;
        if (w_is_mu) addr_mu <= addr_mu + 1'b1;
      end
    end
  end

  assign shake.shake_data_in = w_is_mu ? r_mu_data : w_pack_word;
  assign shake.last_len      = c_len_w'(WORD_WIDTH);

`ifdef W1_RANGE_CHECK_EN
  logic r_range_err;
  logic w_coeff_oor;

  always_comb begin
    w_coeff_oor = 1'b0;
    for (int j = 0; j < COEFF_PER_WORD; j++) begin
      if (dout_w1[j*COEFF_WIDTH+W1_BITS +: COEFF_WIDTH-W1_BITS] != '0) w_coeff_oor = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          r_range_err <= 1'b0;
    else if (w_start_acc)             r_range_err <= 1'b0;
    else if (w_capture && w_coeff_oor) r_range_err <= 1'b1;
  end

  assign range_err = r_range_err;
`endif
endmodule

`default_nettype wire

// File: tb/tb_w1_encode_absorb.sv
// ============================================================================
// tb_w1_encode_absorb : scoreboard bench for w1_encode_absorb with RAM models
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_w1_encode_absorb;
  localparam int TB_MU_BASE = 5;
  localparam int TB_W1_BASE = 4092;
  localparam int TB_MU_WORDS = 8;
  localparam int TB_W1_WORDS = 128;
  localparam int TB_COEFFS = 2048;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic        busy;
  logic [11:0] addr_mu;
  logic [63:0] dout_mu;
  logic [11:0] addr_w1;
  logic [95:0] dout_w1;
`ifdef W1_RANGE_CHECK_EN
  logic        range_err;
`endif

  w1_encode_absorb_if #(.WORD_WIDTH(64)) sif ();

  w1_encode_absorb #(
    .MU_BASE_OFFSET (TB_MU_BASE),
    .W1_BASE_OFFSET (TB_W1_BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done      (done),
    .busy      (busy),
    .addr_mu   (addr_mu),
    .dout_mu   (dout_mu),
    .addr_w1   (addr_w1),
    .dout_w1   (dout_w1),
`ifdef W1_RANGE_CHECK_EN
    .range_err (range_err),
`endif
    .shake     (sif)
  );

  logic [63:0] mu_mem  [4096];
  logic [95:0] ntt_mem [4096];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          done_cnt = 0;
  bit          bp_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAMs: data appears the cycle after the address.
  always @(posedge clk) begin
    dout_mu <= mu_mem[addr_mu];
    dout_w1 <= ntt_mem[addr_w1];
  end

  initial begin
    sif.in_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sif.in_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard queue.
  initial begin
    bit          prev_stall = 0;
    logic [63:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (sif.in_valid && prev_stall) begin
          check("stall_data", sif.shake_data_in, prev_data);
          check("stall_last", 64'(sif.in_last), 64'(prev_last));
        end
        if (!sif.in_valid) check("last_without_valid", 64'(sif.in_last), 64'd0);
        if (sif.in_valid && sif.in_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 64'(hs_count), 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("word%0d_data", hs_count), sif.shake_data_in, e.data);
            check($sformatf("word%0d_last", hs_count), 64'(sif.in_last), 64'(e.last));
            check("last_len", 64'(sif.last_len), 64'd64);
          end
          hs_count++;
        end
        if (done) done_cnt++;
        prev_stall = sif.in_valid && !sif.in_ready;
        prev_data  = sif.shake_data_in;
        prev_last  = sif.in_last;
      end
    end
  end

  // Reference model: mu words verbatim, then 16 truncated coeffs per word, LSB first.
  task automatic fill_and_expect(input int mode, output bit rerr);
    logic [23:0] coeffs [TB_COEFFS];
    logic [63:0] w;
    exp_t        e;
    rerr = 0;
    exp_q.delete();
    for (int k = 0; k < TB_MU_WORDS; k++)
      mu_mem[TB_MU_BASE + k] = (mode == 1) ? {$urandom(), $urandom()} : 64'(k);
    for (int i = 0; i < TB_COEFFS; i++) begin
      case (mode)
        0:       coeffs[i] = 24'(i % 16);
        1:       coeffs[i] = ($urandom_range(0, 3) == 0) ? 24'($urandom()) : 24'($urandom_range(0, 15));
        default: coeffs[i] = (i == 0) ? 24'h00001F : 24'(i % 16);
      endcase
      if (coeffs[i] > 24'd15) rerr = 1;
      ntt_mem[(TB_W1_BASE + i / 4) % 4096][24 * (i % 4) +: 24] = coeffs[i];
    end
    for (int k = 0; k < TB_MU_WORDS; k++) begin
      e.data = mu_mem[TB_MU_BASE + k];
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    for (int wi = 0; wi < TB_W1_WORDS; wi++) begin
      w = '0;
      for (int t = 0; t < 16; t++)
        w = w | (64'(coeffs[16 * wi + t] % 16) << (4 * t));
      e.data = w;
      e.last = (wi == TB_W1_WORDS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_stream(input int mode, input bit bp, input bit inject, input bit chk_lat);
    bit rerr;
    bit seen_done = 0;
    bit injected = 0;
    int n = 0;
    fill_and_expect(mode, rerr);
    bp_en = bp;
    hs_count = 0;
    done_cnt = 0;
    pulse_start();
`ifdef W1_RANGE_CHECK_EN
    check("range_err_clear_on_start", 64'(range_err), 64'd0);
`endif
    while (!seen_done && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
      start = 1'b0;
      if (n == 1) check("busy_after_start", 64'(busy), 64'd1);
      if (done) seen_done = 1;
      else if (inject && !injected && sif.in_valid && hs_count >= 20) begin
        start = 1'b1;
        injected = 1;
      end
    end
    start = 1'b0;
    if (!seen_done) check("done_timeout", 64'(n), 64'd0);
    // n counts the start cycle as 1: done must land in cycle 793.
    else if (chk_lat) check("done_latency", 64'(n), 64'd793);
    repeat (20) @(negedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("words_accepted", 64'(hs_count), 64'd136);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
`ifdef W1_RANGE_CHECK_EN
    check("range_err", 64'(range_err), 64'(rerr));
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bit rerr;
    int n;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_valid", 64'(sif.in_valid), 64'd0);
    check("rst_in_last", 64'(sif.in_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", sif.shake_data_in, 64'd0);
    check("rst_addr_mu", 64'(addr_mu), 64'(TB_MU_BASE));
    check("rst_addr_w1", 64'(addr_w1), 64'(TB_W1_BASE));
`ifdef W1_RANGE_CHECK_EN
    check("rst_range_err", 64'(range_err), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_stream(0, 0, 0, 1);
    run_stream(0, 1, 0, 0);
    run_stream(1, 1, 1, 0);
    run_stream(2, 0, 0, 1);
`ifdef W1_RANGE_CHECK_EN
    repeat (10) @(negedge clk);
    check("range_err_sticky", 64'(range_err), 64'd1);
`endif

    // Abort on the handshake of word 50, then replay from the beginning.
    fill_and_expect(0, rerr);
    bp_en = 0;
    hs_count = 0;
    done_cnt = 0;
    pulse_start();
    n = 0;
    while (hs_count != 51 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (hs_count != 51) check("abort_wait_timeout", 64'(hs_count), 64'd51);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_valid", 64'(sif.in_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_addr_mu", 64'(addr_mu), 64'(TB_MU_BASE));
    check("abort_addr_w1", 64'(addr_w1), 64'(TB_W1_BASE));
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    run_stream(0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
